// File: rtl/seq_serializer.sv
// seq_serializer: one-word buffered parallel-to-serial stage, MSB first.
// Define SER_PARITY_EN to append an even-parity bit after every word.
module seq_serializer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             sof,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef SER_PARITY_EN
    // Data bits plus one parity bit per frame.
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hbuf;
    logic             hfull;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             load;

`ifdef SER_PARITY_EN
    logic par;
`endif

    // The serial bit is the shifter MSB, so dout is a plain register.
    assign dout     = sreg[WIDTH-1];
    assign in_ready = ~rst & ~hfull;
    assign busy     = (state == SHIFT) | hfull;
    assign load     = hfull & ((state == IDLE) | (cnt == '0));

    // Holding buffer, shifter, bit counter and frame FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hbuf       <= '0;
            hfull      <= 1'b0;
            sreg       <= '0;
            cnt        <= '0;
            dout_valid <= 1'b0;
            sof        <= 1'b0;
`ifdef SER_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            if (in_valid && in_ready) begin
                hbuf  <= in_data;
                hfull <= 1'b1;
            end
            if (load) begin
                sreg       <= hbuf;
                hfull      <= 1'b0;
                cnt        <= LAST;
                state      <= SHIFT;
                dout_valid <= 1'b1;
                sof        <= 1'b1;
`ifdef SER_PARITY_EN
                par        <= hbuf[WIDTH-1];
`endif
            end else if (state == SHIFT) begin
                sof <= 1'b0;
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
`ifdef SER_PARITY_EN
                    if (cnt == CW'(1)) begin
                        sreg <= {par, {(WIDTH-1){1'b0}}};
                    end else begin
                        sreg <= {sreg[WIDTH-2:0], 1'b0};
                        par  <= par ^ sreg[WIDTH-2];
                    end
`else
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
`endif
                end else begin
                    state      <= IDLE;
                    sreg       <= '0;
                    dout_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: directed table-driven bench for seq_serializer.
// Frame length follows SER_PARITY_EN.
module tb_seq_serializer;

    localparam int W = 32;
`ifdef SER_PARITY_EN
    localparam int FR = W + 1;
`else
    localparam int FR = W;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         dout;
    logic         dout_valid;
    logic         sof;
    logic         busy;

    seq_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sof        (sof),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] word;
        logic         par;
    } vec_t;

    vec_t tbl [8];
    int   n_pass;
    int   n_total;
    int   sq [$];
    logic cap_bit [$];
    logic cap_sof [$];
    int   cap_cyc [$];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    endtask

    function automatic logic exp_bit(input int idx, input int pos);
        logic [W-1:0] w;
        w = tbl[idx].word;
        if (pos < W) return w[W-1-pos];
        return tbl[idx].par;
    endfunction

    // Present each word in sq, holding in_valid until accepted.
    task automatic send_list();
        int t;
        foreach (sq[i]) begin
            in_data  = tbl[sq[i]].word;
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (t >= 400) chk($sformatf("send_timeout_%0d", i), 0, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int n);
        cap_bit.delete();
        cap_sof.delete();
        cap_cyc.delete();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (dout_valid === 1'b1) begin
                cap_bit.push_back(dout);
                cap_sof.push_back(sof);
                cap_cyc.push_back(c);
            end
        end
    endtask

    task automatic check_stream(input string nm);
        int n;
        int m;
        n = sq.size() * FR;
        m = cap_bit.size();
        chk({nm, "_count"}, m, n);
        for (int j = 0; j < m && j < n; j++) begin
            chk($sformatf("%s_bit%0d", nm, j), {cap_sof[j], cap_bit[j]},
                {(j % FR) == 0, exp_bit(sq[j / FR], j % FR)});
        end
        if (m > 0) chk({nm, "_gapless"}, cap_cyc[m-1] - cap_cyc[0], m - 1);
    endtask

    task automatic run_single(input int idx);
        in_data  = tbl[idx].word;
        in_valid = 1'b1;
        chk($sformatf("s%0d_ready", idx), in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("s%0d_lat", idx), {dout_valid, busy}, 2'b01);
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            chk($sformatf("s%0d_b%0d", idx, i), {dout_valid, sof, dout},
                {1'b1, i == 0, exp_bit(idx, i)});
        end
        @(negedge clk);
        chk($sformatf("s%0d_end", idx), {dout_valid, sof, dout, busy}, 4'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        n_pass  = 0;
        n_total = 0;
        tbl[0] = '{32'hC646A4A2, 1'b1};
        tbl[1] = '{32'h0F0F0F0F, 1'b0};
        tbl[2] = '{32'hFFFF0000, 1'b0};
        tbl[3] = '{32'h00000001, 1'b1};
        tbl[4] = '{32'h00000003, 1'b0};
        tbl[5] = '{32'hA5A5A5A5, 1'b0};
        tbl[6] = '{32'h80000000, 1'b1};
        tbl[7] = '{32'h7FFFFFFF, 1'b1};

        // reset with in_valid high
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d", i),
                {dout, dout_valid, sof, in_ready, busy}, 5'b0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1);
        @(negedge clk);
        chk("rst_noacc", {dout_valid, busy}, 2'b00);

        // single words, one per table entry
        for (int v = 0; v < 8; v++) run_single(v);

        // two words back to back
        sq = '{0, 1};
        fork
            send_list();
            collect(2 * FR + 20);
        join
        check_stream("b2b");

        // three words with in_valid held high
        sq = '{5, 6, 7};
        fork
            send_list();
            collect(3 * FR + 20);
        join
        check_stream("held");

        // reset on 10th bit with a buffered word
        sq = '{0, 1};
        fork
            send_list();
            begin
                n = 0;
                for (int t = 0; t < 200 && n < 10; t++) begin
                    @(negedge clk);
                    if (dout_valid === 1'b1) n++;
                end
            end
        join
        chk("mid_tenth", n, 10);
        chk("mid_buffered", {in_ready, busy}, 2'b01);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst", {dout_valid, sof, dout, busy, in_ready}, 5'b0);
        rst = 1'b0;
        #1;
        chk("mid_ready", in_ready, 1);
        collect(FR + 8);
        chk("mid_lost", cap_bit.size(), 0);
        run_single(2);

        // parity pair (plain pair when parity is off)
        sq = '{3, 4};
        fork
            send_list();
            collect(2 * FR + 20);
        join
        check_stream("pair");
`ifdef SER_PARITY_EN
        chk("par_33", cap_bit.size() > 32 ? cap_bit[32] : 1'bx, 1);
        chk("par_66", cap_bit.size() > 65 ? cap_bit[65] : 1'bx, 0);
        chk("par_sof33", cap_sof.size() > 33 ? cap_sof[33] : 1'bx, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
